// File: rtl/cc_level_pkg.sv
// Shared definitions for the level sequencer: state encoding, banner digit images,
// obstacle row tables and per-level lengths.
package cc_level_pkg;

   typedef enum logic [1:0] {StIdle, StBanner, StLevel, StDone} seqState_t;

   localparam int LevelCount = 3;
   localparam int BannerLen  = 8;

   localparam logic [7:0] Banner1Rows [8] = '{
      8'b00011000, 8'b00111000, 8'b00011000, 8'b00011000,
      8'b00011000, 8'b00011000, 8'b00111100, 8'b00000000
   };

   localparam logic [7:0] Banner2Rows [8] = '{
      8'b00011100, 8'b00100010, 8'b00000010, 8'b00000100,
      8'b00001000, 8'b00010000, 8'b00111110, 8'b00000000
   };

   localparam logic [7:0] Banner3Rows [8] = '{
      8'b00011100, 8'b00100010, 8'b00000010, 8'b00001100,
      8'b00000010, 8'b00100010, 8'b00011100, 8'b00000000
   };

   localparam logic [7:0] Lvl1Rows [10] = '{
      8'b00100000, 8'b10000000, 8'b00001000, 8'b01000010, 8'b00010000,
      8'b10000001, 8'b00100100, 8'b00000010, 8'b01001000, 8'b00010001
   };

   localparam logic [7:0] Lvl2Rows [15] = '{
      8'b01000000, 8'b00010010, 8'b10000100, 8'b00100001, 8'b01001000,
      8'b00000110, 8'b10010000, 8'b00101000, 8'b01000001, 8'b00011000,
      8'b10000010, 8'b00100100, 8'b01010000, 8'b00001001, 8'b10100000
   };

   localparam logic [7:0] Lvl3Rows [20] = '{
      8'b10010010, 8'b01001001, 8'b00100100, 8'b10010001, 8'b01000110,
      8'b00101001, 8'b10001100, 8'b01100010, 8'b00011001, 8'b10100100,
      8'b01010010, 8'b00101101, 8'b10010100, 8'b01001010, 8'b00110001,
      8'b10001010, 8'b01100100, 8'b00010110, 8'b10101000, 8'b00100000
   };

   function automatic logic [4:0] levelLen(input logic [2:0] lvl);
      case (lvl)
         3'd1:    levelLen = 5'd10;
         3'd2:    levelLen = 5'd15;
         3'd3:    levelLen = 5'd20;
         default: levelLen = 5'd0;
      endcase
   endfunction

   function automatic logic [7:0] bannerRow(input logic [2:0] lvl, input logic [4:0] idx);
      bannerRow = 8'h00;
      if (idx < 5'(BannerLen)) begin
         case (lvl)
            3'd1:    bannerRow = Banner1Rows[idx[2:0]];
            3'd2:    bannerRow = Banner2Rows[idx[2:0]];
            3'd3:    bannerRow = Banner3Rows[idx[2:0]];
            default: bannerRow = 8'h00;
         endcase
      end
   endfunction

   function automatic logic [7:0] levelRow(input logic [2:0] lvl, input logic [4:0] idx);
      levelRow = 8'h00;
      if (idx < levelLen(lvl)) begin
         case (lvl)
            3'd1:    levelRow = Lvl1Rows[idx[3:0]];
            3'd2:    levelRow = Lvl2Rows[idx[3:0]];
            3'd3:    levelRow = Lvl3Rows[idx];
            default: levelRow = 8'h00;
         endcase
      end
   endfunction

endpackage

// File: rtl/cc_level_rom.sv
// Combinational row lookup by (level, phase, index); zero for any out-of-range index.
// Banner images are only present when CC_LEVEL_SEQUENCER_BANNER_EN is defined.
module cc_level_rom
   import cc_level_pkg::*;
#(
   parameter int DATAWIDTH      = 8,
   parameter int LEVEL_WIDTH    = 3,
   parameter int PROGRESS_WIDTH = 5,
   parameter int MAX_ROWS       = 20
) (
   input  logic [LEVEL_WIDTH-1:0]    level,
   input  logic                      bannerPhase,
   input  logic [PROGRESS_WIDTH-1:0] index,
   output logic [DATAWIDTH-1:0]      row
);

   logic [7:0] tableRow;

   always_comb begin
      tableRow = 8'h00;
      if (int'(index) < MAX_ROWS) begin
`ifdef CC_LEVEL_SEQUENCER_BANNER_EN
         if (bannerPhase) begin
            tableRow = bannerRow(3'(level), 5'(index));
         end else begin
            tableRow = levelRow(3'(level), 5'(index));
         end
`else
         if (!bannerPhase) begin
            tableRow = levelRow(3'(level), 5'(index));
         end
`endif
      end
      row = DATAWIDTH'(tableRow);
   end

endmodule

// File: rtl/cc_level_sequencer.sv
// Paced level row streamer: optional banner, then the level's obstacle rows over valid/ready.
// CC_LEVEL_SEQUENCER_BANNER_EN enables the 8-row banner phase ahead of the level rows.
module cc_level_sequencer
   import cc_level_pkg::*;
#(
   parameter int DATAWIDTH      = 8,
   parameter int NUM_LEVELS     = 3,
   parameter int LEVEL_WIDTH    = 3,
   parameter int PROGRESS_WIDTH = 5,
   parameter int MAX_ROWS       = 20,
   parameter int BANNER_ROWS    = 8
) (
   input  logic                      CC_LEVEL_SEQUENCER_CLOCK_50,
   input  logic                      CC_LEVEL_SEQUENCER_RESET_InHigh,
   input  logic                      CC_LEVEL_SEQUENCER_Start_In,
   input  logic [LEVEL_WIDTH-1:0]    CC_LEVEL_SEQUENCER_Level_InBus,
   input  logic                      CC_LEVEL_SEQUENCER_Abort_In,
   input  logic                      CC_LEVEL_SEQUENCER_Tick_In,
   input  logic                      CC_LEVEL_SEQUENCER_Ready_In,
   output logic [DATAWIDTH-1:0]      CC_LEVEL_SEQUENCER_Data_OutBus,
   output logic                      CC_LEVEL_SEQUENCER_Valid_Out,
   output logic                      CC_LEVEL_SEQUENCER_Busy_Out,
   output logic                      CC_LEVEL_SEQUENCER_Banner_Out,
   output logic [PROGRESS_WIDTH-1:0] CC_LEVEL_SEQUENCER_Progress_OutBus,
   output logic [LEVEL_WIDTH-1:0]    CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
   output logic                      CC_LEVEL_SEQUENCER_Done_Out,
   output logic                      CC_LEVEL_SEQUENCER_Error_Out
);

`ifdef CC_LEVEL_SEQUENCER_BANNER_EN
   localparam seqState_t FirstPhase = StBanner;
`else
   localparam seqState_t FirstPhase = StLevel;
`endif

   seqState_t                 stateReg, stateNext;
   logic [LEVEL_WIDTH-1:0]    levelReg;
   logic [PROGRESS_WIDTH-1:0] rowCount, lastIdx;
   logic [DATAWIDTH-1:0]      dataReg, romRow;
   logic                      validReg, errorReg;
   logic                      levelOk, inStream, transfer, lastTransfer;

   assign levelOk = (CC_LEVEL_SEQUENCER_Level_InBus != '0)
                 && (int'(CC_LEVEL_SEQUENCER_Level_InBus) <= NUM_LEVELS);
   assign inStream = (stateReg == StBanner) || (stateReg == StLevel);

   // Abort wins over a transfer happening in the same cycle.
   assign transfer = inStream && validReg && CC_LEVEL_SEQUENCER_Ready_In
                  && !CC_LEVEL_SEQUENCER_Abort_In;

   always_comb begin
      if (stateReg == StBanner) begin
         lastIdx = PROGRESS_WIDTH'(BANNER_ROWS - 1);
      end else begin
         lastIdx = PROGRESS_WIDTH'(levelLen(3'(levelReg)) - 5'd1);
      end
   end

   assign lastTransfer = transfer && (rowCount == lastIdx);

   cc_level_rom #(
      .DATAWIDTH     (DATAWIDTH),
      .LEVEL_WIDTH   (LEVEL_WIDTH),
      .PROGRESS_WIDTH(PROGRESS_WIDTH),
      .MAX_ROWS      (MAX_ROWS)
   ) uRom (
      .level      (levelReg),
      .bannerPhase(stateReg == StBanner),
      .index      (rowCount),
      .row        (romRow)
   );

   always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or posedge CC_LEVEL_SEQUENCER_RESET_InHigh) begin
      if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
         stateReg <= StIdle;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      if (CC_LEVEL_SEQUENCER_Abort_In && (stateReg != StIdle)) begin
         stateNext = StIdle;
      end else begin
         case (stateReg)
            StIdle: begin
               if (CC_LEVEL_SEQUENCER_Start_In && levelOk) begin
                  stateNext = FirstPhase;
               end
            end
`ifdef CC_LEVEL_SEQUENCER_BANNER_EN
            StBanner: begin
               if (lastTransfer) begin
                  stateNext = StLevel;
               end
            end
`endif
            StLevel: begin
               if (lastTransfer) begin
                  stateNext = StDone;
               end
            end
            StDone:  stateNext = StIdle;
            default: stateNext = StIdle;
         endcase
      end
   end

   always_comb begin
      CC_LEVEL_SEQUENCER_Busy_Out = (stateReg != StIdle);
      CC_LEVEL_SEQUENCER_Done_Out = (stateReg == StDone);
`ifdef CC_LEVEL_SEQUENCER_BANNER_EN
      CC_LEVEL_SEQUENCER_Banner_Out = (stateReg == StBanner);
`else
      CC_LEVEL_SEQUENCER_Banner_Out = 1'b0;
`endif
   end

   always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or posedge CC_LEVEL_SEQUENCER_RESET_InHigh) begin
      if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
         levelReg <= '0;
         rowCount <= '0;
         dataReg  <= '0;
         validReg <= 1'b0;
         errorReg <= 1'b0;
      end else begin
         errorReg <= 1'b0;
         if (stateReg == StIdle) begin
            if (CC_LEVEL_SEQUENCER_Start_In) begin
               if (levelOk) begin
                  levelReg <= CC_LEVEL_SEQUENCER_Level_InBus;
                  rowCount <= '0;
               end else begin
                  errorReg <= 1'b1;
               end
            end
         end else if (CC_LEVEL_SEQUENCER_Abort_In) begin
            validReg <= 1'b0;
         end else if (transfer) begin
            validReg <= 1'b0;
            // Banner end restarts the count for the level; level end keeps the final count.
            if (lastTransfer && (stateReg == StBanner)) begin
               rowCount <= '0;
            end else begin
               rowCount <= rowCount + PROGRESS_WIDTH'(1);
            end
         end else if (inStream && !validReg && CC_LEVEL_SEQUENCER_Tick_In) begin
            dataReg  <= romRow;
            validReg <= 1'b1;
         end
      end
   end

   assign CC_LEVEL_SEQUENCER_Data_OutBus       = dataReg;
   assign CC_LEVEL_SEQUENCER_Valid_Out         = validReg;
   assign CC_LEVEL_SEQUENCER_Progress_OutBus   = rowCount;
   assign CC_LEVEL_SEQUENCER_CurrentLvl_OutBus = levelReg;
   assign CC_LEVEL_SEQUENCER_Error_Out         = errorReg;

endmodule

// File: doc/cc_level_sequencer.md
# cc_level_sequencer

Paced row streamer for the Frogger level playfield, replacing the purely combinational level lookup. On a start request it plays an 8-row level banner and then the selected level's obstacle rows, one row per pacing tick. Each row is delivered to the matrix/scroll logic over a valid/ready handshake. It sits between the game-control FSM, which issues start/abort, and the playfield shift register, which consumes rows.

## Interface
- DATAWIDTH, 8, row width in bits (one matrix column set per row)
- NUM_LEVELS, 3, number of playable levels (1..7)
- LEVEL_WIDTH, 3, width of level-number buses
- PROGRESS_WIDTH, 5, width of the row counter; must hold MAX_ROWS
- MAX_ROWS, 20, longest level in rows
- BANNER_ROWS, 8, rows per banner image

Ports:
- CC_LEVEL_SEQUENCER_CLOCK_50  in  1  system clock
- CC_LEVEL_SEQUENCER_RESET_InHigh  in  1  asynchronous, active-high reset
- CC_LEVEL_SEQUENCER_Start_In  in  1  one-cycle start request
- CC_LEVEL_SEQUENCER_Level_InBus  in  LEVEL_WIDTH  requested level, sampled with Start_In
- CC_LEVEL_SEQUENCER_Abort_In  in  1  cancel current stream
- CC_LEVEL_SEQUENCER_Tick_In  in  1  pacing strobe from prescaler
- CC_LEVEL_SEQUENCER_Ready_In  in  1  consumer accepts row
- CC_LEVEL_SEQUENCER_Data_OutBus  out  DATAWIDTH  row data
- CC_LEVEL_SEQUENCER_Valid_Out  out  1  row data valid
- CC_LEVEL_SEQUENCER_Busy_Out  out  1  state is not IDLE
- CC_LEVEL_SEQUENCER_Banner_Out  out  1  current row belongs to the banner
- CC_LEVEL_SEQUENCER_Progress_OutBus  out  PROGRESS_WIDTH  rows transferred in the current phase
- CC_LEVEL_SEQUENCER_CurrentLvl_OutBus  out  LEVEL_WIDTH  latched level
- CC_LEVEL_SEQUENCER_Done_Out  out  1  one-cycle pulse after the last level row transfers
- CC_LEVEL_SEQUENCER_Error_Out  out  1  one-cycle pulse on an invalid start

## Operation
- States: IDLE, BANNER, LEVEL, DONE.
- IDLE:
  - Start_In with level in 1..NUM_LEVELS: latch the level, clear index and Progress, go to BANNER.
  - Start_In with level 0 or level > NUM_LEVELS: pulse Error_Out and stay in IDLE.
- BANNER and LEVEL, row fetch and transfer:
  - When Valid_Out=0 and Tick_In=1: register ROM[level, phase, index] into Data_OutBus and set Valid_Out.
  - A transfer occurs when Valid_Out=1 and Ready_In=1. On transfer, clear Valid_Out, increment index, and increment Progress.
  - Ticks arriving while Valid_Out=1 are dropped, not queued.
- Phase ends on the transfer of the last row. BANNER is BANNER_ROWS rows; LEVEL is LEN[level] rows, with LEN = 10/15/20 for levels 1/2/3.
  - BANNER to LEVEL: index and Progress reset to 0.
  - LEVEL to DONE.
- DONE lasts one cycle. It pulses Done_Out and returns to IDLE. Progress holds its final value until the next start.
- Start_In is ignored while Busy_Out=1.
- Abort_In in any non-IDLE state: go to IDLE next cycle, clear Valid_Out, no Done_Out pulse. Abort has priority over a simultaneous transfer.
- Banner_Out=1 exactly while the state is BANNER.
- Data_OutBus holds its value after a transfer and is not cleared.
- Index arithmetic is unsigned PROGRESS_WIDTH and never wraps, because the terminal compare precedes the increment.

## Timing
- Reset values: Data_OutBus=0, Valid_Out=0, Busy_Out=0, Banner_Out=0, Progress=0, CurrentLvl=0, Done_Out=0, Error_Out=0, state IDLE.
- Start → BANNER (Busy_Out=1) on the next edge.
- Tick_In → Valid_Out one cycle later.
- Minimum row period is 2 cycles: fetch, then transfer with Ready_In held high.
- Ready_In low stalls the stream indefinitely. Data_OutBus is stable while Valid_Out=1.
- Last level transfer → Done_Out one cycle later → Busy_Out=0 the cycle after that.
- Reset mid-stream forces reset values asynchronously. No partial row is emitted afterwards.

## Configuration
- CC_LEVEL_SEQUENCER_BANNER_EN defined: behaviour as above.
- CC_LEVEL_SEQUENCER_BANNER_EN undefined: BANNER state and banner ROM are removed. A valid start goes directly to LEVEL, and Banner_Out is tied 0.

## Structure
- Shared package cc_level_pkg holds:
  - state encoding
  - level row tables (LVL1 10, LVL2 15, LVL3 20 rows; LVL1 row0 8'b00100000, row1 8'b10000000)
  - banner digit images ("1" starts 8'b00011000, "2" starts 8'b00011100, "3" starts 8'b00011100)
  - LEN table
- One sub-module, cc_level_rom: combinational lookup of (level, phase, index) → row. It returns 0 for any out-of-range index.

## Test plan
- Start level 1: first row 8'b00011000 with Banner_Out=1; 9th transfer is 8'b00100000 with Banner_Out=0; Done_Out pulses one cycle after the 18th transfer; Progress=10.
- Ready_In held low for 5 cycles with Valid_Out=1: Data_OutBus is constant, Progress does not advance, and intervening ticks are dropped.
- Start with level 0, then level 4 (NUM_LEVELS=3): Error_Out pulses each time, Busy_Out stays 0.
- Level 3 run: 20th level row is 8'b00100000, then Done_Out; a Start_In issued mid-run is ignored.
- Abort_In at level row 5: Valid_Out=0 and Busy_Out=0 next cycle, no Done_Out; a new start then begins at banner row 0.
- Reset asserted during LEVEL: all outputs return to reset values immediately, and the sequencer stays idle until Start_In.
